// File: rtl/in_sa_row_sched.sv
// Input-side row scheduler for a systolic array: streams K vectors and skews row i by i+1 cycles.
// Optional build macro IN_SA_ROW_SCHED_ZERO_PAD_EN forces lane data to zero whenever its valid is low.
module in_sa_row_sched #(
    parameter int unsigned ROW    = 8,
    parameter int unsigned W_DATA = 8,
    parameter int unsigned W_LEN  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [W_LEN-1:0]      i_len,
    input  logic [W_DATA*ROW-1:0] i_vec,
    input  logic                  i_vec_valid,
    output logic                  o_vec_ready,
    output logic [W_DATA*ROW-1:0] o_data,
    output logic [ROW-1:0]        o_data_valid,
    output logic                  o_busy,
    output logic                  o_done
);
    localparam int unsigned W_DCNT = (ROW > 1) ? $clog2(ROW) : 1;

    typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

    state_e             state_q, state_d;
    logic [W_LEN-1:0]   len_q;
    logic [W_LEN-1:0]   beat_q;
    logic [W_DCNT-1:0]  dcnt_q;
    logic               zdone_q;
    logic               start_ok;
    logic               accept;
    logic               last_beat;
    logic               drain_end;

    assign start_ok    = (state_q == StIdle) && i_start;
    assign o_vec_ready = (state_q == StStream);
    assign accept      = i_vec_valid && o_vec_ready;
    assign last_beat   = accept && (beat_q == (len_q - W_LEN'(1)));
    assign drain_end   = (state_q == StDrain) && (dcnt_q == W_DCNT'(ROW - 1));
    assign o_busy      = (state_q != StIdle);
    // Zero-length tiles complete immediately without ever leaving IDLE.
    assign o_done      = zdone_q || drain_end;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (i_start && (i_len != '0)) state_d = StStream;
            StStream: if (last_beat) state_d = StDrain;
            StDrain:  if (drain_end) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            len_q   <= '0;
            beat_q  <= '0;
            dcnt_q  <= '0;
            zdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            zdone_q <= start_ok && (i_len == '0);
            if (start_ok) begin
                len_q  <= i_len;
                beat_q <= '0;
            end else if (accept) begin
                beat_q <= beat_q + W_LEN'(1);
            end
            if (state_q == StDrain) dcnt_q <= dcnt_q + W_DCNT'(1);
            else                    dcnt_q <= '0;
        end
    end

    // Row r is a shift line of r+1 stages; bubbles travel as valid=0 entries.
    for (genvar r = 0; r < ROW; r++) begin : g_row
        for (genvar j = 0; j <= r; j++) begin : g_stage
            logic              v_q;
            logic [W_DATA-1:0] d_q;
            logic              in_v;
            logic [W_DATA-1:0] in_d;

            if (j == 0) begin : g_head
                assign in_v = accept;
                assign in_d = i_vec[(W_DATA*(ROW-r))-1 -: W_DATA];
            end else begin : g_body
                assign in_v = g_stage[j-1].v_q;
                assign in_d = g_stage[j-1].d_q;
            end

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    v_q <= 1'b0;
                    d_q <= '0;
                end else begin
                    v_q <= in_v;
`ifdef IN_SA_ROW_SCHED_ZERO_PAD_EN
                    d_q <= in_v ? in_d : '0;
`else
                    if (in_v) d_q <= in_d;
`endif
                end
            end
        end

        assign o_data[(W_DATA*(ROW-r))-1 -: W_DATA] = g_stage[r].d_q;
        assign o_data_valid[r]                      = g_stage[r].v_q;
    end

endmodule

// File: tb/tb_in_sa_row_sched.sv
// Scoreboard bench for in_sa_row_sched: the driver queues expected per-row beats and done pulses,
// a negedge monitor pops and compares them against the DUT outputs every cycle.
module tb_in_sa_row_sched;
    localparam int ROW    = 8;
    localparam int W_DATA = 8;
    localparam int W_LEN  = 8;

    typedef struct {
        int                cyc;
        int                row;
        logic [W_DATA-1:0] d;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [W_LEN-1:0]      len;
    logic [W_DATA*ROW-1:0] vec;
    logic                  vec_valid;
    logic                  vec_ready;
    logic [W_DATA*ROW-1:0] data;
    logic [ROW-1:0]        dvalid;
    logic                  busy;
    logic                  done;

    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];
    int   done_q[$];
    logic [W_DATA-1:0] last_d [ROW];

    in_sa_row_sched #(.ROW(ROW), .W_DATA(W_DATA), .W_LEN(W_LEN)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_len        (len),
        .i_vec        (vec),
        .i_vec_valid  (vec_valid),
        .o_vec_ready  (vec_ready),
        .o_data       (data),
        .o_data_valid (dvalid),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, expv);
        end
    endtask

    function automatic logic [W_DATA-1:0] lane(input logic [W_DATA*ROW-1:0] v, input int i);
        return v[(W_DATA*(ROW-i))-1 -: W_DATA];
    endfunction

    // Lane i of beat b carries b in the upper nibble and the row index in the lower nibble.
    function automatic logic [W_DATA*ROW-1:0] mk_vec(input int beat);
        logic [W_DATA*ROW-1:0] v;
        v = '0;
        for (int i = 0; i < ROW; i++) v[(W_DATA*(ROW-i))-1 -: W_DATA] = W_DATA'(beat * 16 + i);
        return v;
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctl(input bit exp_ready, input bit exp_busy);
        @(negedge clk);
        check("vec_ready", 64'(vec_ready), 64'(exp_ready));
        check("busy", 64'(busy), 64'(exp_busy));
    endtask

    task automatic push_beat(input int beat);
        exp_t e;
        vec       = mk_vec(beat);
        vec_valid = 1'b1;
        for (int i = 0; i < ROW; i++) begin
            e.cyc = cyc + 1 + i;
            e.row = i;
            e.d   = lane(vec, i);
            exp_q.push_back(e);
        end
    endtask

    task automatic flush_model();
        exp_q.delete();
        done_q.delete();
        for (int i = 0; i < ROW; i++) last_d[i] = '0;
    endtask

    // k beats; optional single bubble after beat bub; extra keeps valid high into DRAIN;
    // poke re-asserts start mid-stream and in the done cycle; rst_beat aborts the tile.
    task automatic run_tile(input int k, input int bub, input bit extra, input bit poke,
                            input int rst_beat);
        int beat;
        int last;
        bit bubbled;
        next();
        start     = 1'b1;
        len       = W_LEN'(k);
        vec_valid = 1'b0;
        check_ctl(1'b0, 1'b0);
        next();
        start   = 1'b0;
        len     = W_LEN'(1);
        beat    = 0;
        bubbled = 1'b0;
        while (beat < k) begin
            if (bub != 0 && beat == bub && !bubbled) begin
                vec_valid = 1'b0;
                vec       = mk_vec(9);
                bubbled   = 1'b1;
            end else begin
                beat++;
                push_beat(beat);
            end
            start = poke && (beat == 2);
            if (rst_beat != 0 && beat == rst_beat) begin
                rst = 1'b1;
                check_ctl(1'b1, 1'b1);
                next();
                rst       = 1'b0;
                vec_valid = 1'b0;
                start     = 1'b0;
                flush_model();
                @(negedge clk);
                check("rst_data", data, 64'(0));
                check("rst_valid", 64'(dvalid), 64'(0));
                check("rst_busy", 64'(busy), 64'(0));
                check("rst_ready", 64'(vec_ready), 64'(0));
                check("rst_done", 64'(done), 64'(0));
                return;
            end
            check_ctl(1'b1, 1'b1);
            next();
        end
        last = cyc - 1;
        done_q.push_back(last + ROW);
        start     = 1'b0;
        vec_valid = extra;
        for (int d = 1; d <= ROW; d++) begin
            if (d == 3) vec_valid = 1'b0;
            start = poke && (d == ROW);
            len   = W_LEN'(3);
            check_ctl(1'b0, 1'b1);
            next();
        end
        start = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check_ctl(1'b0, 1'b0);
            next();
        end
    endtask

    always @(negedge clk) begin : mon
        logic              ev [ROW];
        logic [W_DATA-1:0] ed [ROW];
        exp_t              keep[$];
        bit                exp_done;
        if (mon_en) begin
            keep.delete();
            for (int i = 0; i < ROW; i++) begin
                ev[i] = 1'b0;
                ed[i] = '0;
            end
            foreach (exp_q[k]) begin
                if (exp_q[k].cyc == cyc) begin
                    ev[exp_q[k].row] = 1'b1;
                    ed[exp_q[k].row] = exp_q[k].d;
                end else if (exp_q[k].cyc < cyc) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL missing_beat row%0d @cyc %0d: got none expected %0h at cyc %0d",
                             exp_q[k].row, cyc, exp_q[k].d, exp_q[k].cyc);
                end else begin
                    keep.push_back(exp_q[k]);
                end
            end
            exp_q = keep;
            for (int i = 0; i < ROW; i++) begin
                if (ev[i] || dvalid[i])
                    check($sformatf("row%0d_valid", i), 64'(dvalid[i]), 64'(ev[i]));
                if (ev[i]) begin
                    check($sformatf("row%0d_data", i), 64'(lane(data, i)), 64'(ed[i]));
                    last_d[i] = ed[i];
                end else begin
`ifdef IN_SA_ROW_SCHED_ZERO_PAD_EN
                    check($sformatf("row%0d_pad", i), 64'(lane(data, i)), 64'(0));
`else
                    check($sformatf("row%0d_hold", i), 64'(lane(data, i)), 64'(last_d[i]));
`endif
                end
            end
            exp_done = (done_q.size() > 0) && (done_q[0] == cyc);
            if (exp_done || done) check("done", 64'(done), 64'(exp_done));
            if (exp_done) void'(done_q.pop_front());
        end
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        vec       = '0;
        vec_valid = 1'b0;
        flush_model();
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(negedge clk);
        check("reset_data", data, 64'(0));
        check("reset_valid", 64'(dvalid), 64'(0));
        check("reset_ready", 64'(vec_ready), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        next();
        rst = 1'b0;
        check_ctl(1'b0, 1'b0);

        run_tile(4, 0, 1'b1, 1'b0, 0);   // K=4, valid held high, done 12 cycles after start
        run_tile(3, 1, 1'b0, 1'b0, 0);   // one bubble after beat 1

        // Zero-length start: done next cycle, never busy.
        next();
        start = 1'b1;
        len   = '0;
        done_q.push_back(cyc + 1);
        check_ctl(1'b0, 1'b0);
        next();
        start = 1'b0;
        check_ctl(1'b0, 1'b0);
        next();
        check_ctl(1'b0, 1'b0);

        run_tile(4, 0, 1'b0, 1'b1, 0);   // start pokes ignored
        run_tile(6, 0, 1'b0, 1'b0, 3);   // reset at beat 3
        run_tile(2, 0, 1'b0, 1'b0, 0);   // normal completion after abort
        run_tile(255, 0, 1'b0, 1'b0, 0); // maximum length

        repeat (ROW + 2) next();
        check("queue_drained", 64'(exp_q.size() + done_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/in_sa_row_sched.md
IN_SA_ROW_SCHED -- requirements
Module: in_sa_row_sched

Interface
REQ-001 Parameter ROW, default 8: systolic array rows (lanes).
REQ-002 Parameter W_DATA, default 8: bits per lane.
REQ-003 Parameter W_LEN, default 8: width of the tile-length field.
REQ-004 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 i_rst  input  1  reset, synchronous, active-high.
REQ-006 i_start  input  1  one-cycle command pulse; honoured only in IDLE.
REQ-007 i_len  input  W_LEN  tile length K in vectors; sampled with i_start.
REQ-008 i_vec  input  W_DATA*ROW  input vector; row i lane = i_vec[(W_DATA*(ROW-i))-1 -: W_DATA] (row 0 in MSBs).
REQ-009 i_vec_valid  input  1  i_vec valid.
REQ-010 o_vec_ready  output  1  block accepts i_vec this cycle.
REQ-011 o_data  output  W_DATA*ROW  skewed row data, same lane mapping as i_vec.
REQ-012 o_data_valid  output  ROW  per-row valid; bit i qualifies row i lane.
REQ-013 o_busy  output  1  high in STREAM and DRAIN.
REQ-014 o_done  output  1  one-cycle pulse at tile completion.

Function
REQ-015 FSM states IDLE, STREAM, DRAIN; o_busy = (state != IDLE).
REQ-016 IDLE: o_vec_ready=0; i_start with i_len!=0 latches K and loads beat counter with 0, goes to STREAM next cycle.
REQ-017 IDLE: i_start with i_len==0 produces o_done pulse next cycle, stays IDLE, no data output.
REQ-018 i_start outside IDLE ignored; i_len changes outside the i_start cycle ignored.
REQ-019 STREAM: o_vec_ready=1 combinationally from state; beat accepted when i_vec_valid & o_vec_ready.
REQ-020 Each accepted beat increments beat counter; acceptance of beat K moves to DRAIN next cycle; o_vec_ready=0 from that cycle.
REQ-021 STREAM cycle with i_vec_valid=0 inserts a bubble (valid 0) into every skew line; counter unchanged.
REQ-022 Skew: beat accepted in cycle c appears on row i lane with o_data_valid[i]=1 in cycle c+1+i exactly; per-row shift register depth i+1.
REQ-023 Bubbles propagate with identical timing; o_data_valid[i] never high except for an accepted beat.
REQ-024 DRAIN lasts exactly ROW cycles (drain counter 0..ROW-1); skew lines keep shifting with bubbles entering.
REQ-025 o_done=1 in last DRAIN cycle, coincident with o_data_valid[ROW-1] for beat K; state IDLE next cycle.
REQ-026 Tile of K beats with no bubbles: rows present K consecutive valid cycles each; start-to-done = K+ROW+1 cycles from i_start cycle.
REQ-027 K counter width W_LEN; K=2^W_LEN-1 fully supported, no wrap.
REQ-028 i_start in the cycle o_done is high ignored (state not yet IDLE).

Reset
REQ-029 i_rst high: state IDLE, counters 0, all skew registers (data and valid) 0.
REQ-030 During and after reset until next start: o_data=0, o_data_valid=0, o_vec_ready=0, o_busy=0, o_done=0.
REQ-031 Reset mid-STREAM/DRAIN abandons the tile: no o_done, in-flight beats discarded, valids low from the cycle after reset asserted.

Configuration
REQ-032 Macro IN_SA_ROW_SCHED_ZERO_PAD_EN.
REQ-033 Defined: data register of a skew stage loads 0 when its incoming valid is 0; o_data lane is 0 whenever its valid bit is 0.
REQ-034 Undefined: data register of a skew stage loads only when incoming valid is 1, otherwise holds; valid timing identical in both builds.

Verification
REQ-035 ROW=8, K=4, i_vec_valid constant 1, beats 0x01..,0x02..,0x03..,0x04.. -> row i valid cycles c0+1+i..c0+4+i, o_done at cycle of row 7 beat 4, total 13 cycles from i_start.
REQ-036 K=3 with i_vec_valid low for one cycle after beat 1 -> one-cycle valid gap on every row, delayed by row index; o_done one cycle later than no-bubble case.
REQ-037 i_len=0 start -> o_done pulse next cycle, o_busy never high, o_data_valid stays 0.
REQ-038 i_start asserted again during STREAM and in o_done cycle -> ignored; tile length unchanged; no second done.
REQ-039 i_rst asserted when beat 3 of K=6 accepted -> all outputs 0 next cycle, no o_done, new start then completes normally.
REQ-040 Both builds, bubble cycle -> macro defined: lane data 0; undefined: lane holds previous beat value; valids identical.
